// File: rtl/ex_alu_stage.sv
// ex_alu_stage: MIPS execute-stage ALU with exception detection and EX/MEM register
//   clk, rst_n                      clock, asynchronous active-low reset
//   ex_valid, AluCtrlOut, undefine  instruction validity, ALU op code, reserved-instruction flag
//   ex_a, ex_b, ex_wdata, ex_rd     operands, store data, destination register
//   ex_regwrite/memread/memwrite    control bits from ID/EX
//   ex_pc                           PC of the instruction in EX
//   stall, flush, exc_ack           pipeline hold, squash, handler acknowledge
//   mem_*                           registered EX/MEM fields
//   exc_req, exc_code, exc_epc      held exception request to CP0
module ex_alu_stage #(
    parameter int WIDTH    = 32,
    parameter int OVF_TRAP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [2:0]       AluCtrlOut,
    input  logic             undefine,
    input  logic [WIDTH-1:0] ex_a,
    input  logic [WIDTH-1:0] ex_b,
    input  logic [WIDTH-1:0] ex_wdata,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic             ex_memwrite,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic             stall,
    input  logic             flush,
    input  logic             exc_ack,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_alu_result,
    output logic             mem_zero,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [4:0]       mem_rd,
    output logic             mem_regwrite,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             exc_req,
    output logic [1:0]       exc_code,
    output logic [WIDTH-1:0] exc_epc
);
    typedef enum logic {S_RUN, S_EXC} state_t;
    localparam logic TRAP = (OVF_TRAP != 0);
    state_t state_q, state_d;
    logic valid_q, valid_d, zero_q, zero_d;
    logic regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
    logic exc_req_q, exc_req_d;
    logic [1:0] exc_code_q, exc_code_d;
    logic [4:0] rd_q, rd_d;
    logic [WIDTH-1:0] result_q, result_d, wdata_q, wdata_d, epc_q, epc_d;
    logic [WIDTH-1:0] sum, diff, lui, result;
    logic slt, ovf, rsvd, exc_cond;
    assign sum  = ex_a + ex_b;
    assign diff = ex_a - ex_b;
    assign slt  = $signed(ex_a) < $signed(ex_b);
    assign lui  = {{(WIDTH-16){1'b0}}, ex_b[15:0]} << 16;
    assign result = AluCtrlOut == 3'b000 ? ex_a & ex_b :
                    AluCtrlOut == 3'b001 ? ex_a | ex_b :
                    AluCtrlOut == 3'b010 ? sum :
                    AluCtrlOut == 3'b110 ? diff :
                    AluCtrlOut == 3'b111 ? {{(WIDTH-1){1'b0}}, slt} :
                    AluCtrlOut == 3'b011 ? ex_a ^ ex_b :
                    AluCtrlOut == 3'b101 ? lui : '0;
    // Overflow is only meaningful for the op that is actually selected.
    assign ovf = AluCtrlOut == 3'b010 ? (ex_a[WIDTH-1] == ex_b[WIDTH-1]) && (sum[WIDTH-1] != ex_a[WIDTH-1]) :
                 AluCtrlOut == 3'b110 ? (ex_a[WIDTH-1] != ex_b[WIDTH-1]) && (diff[WIDTH-1] != ex_a[WIDTH-1]) :
                 1'b0;
    assign rsvd     = undefine | (AluCtrlOut == 3'b100);
    assign exc_cond = ex_valid & (rsvd | (TRAP & ovf));
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        result_d   = result_q;
        zero_d     = zero_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        exc_req_d  = exc_req_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (state_q == S_EXC) begin
            // Bubbles flow into MEM until the handler takes the exception.
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
            if (exc_ack) begin
                exc_req_d  = 1'b0;
                exc_code_d = 2'b00;
                state_d    = S_RUN;
            end
        end else if (flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
            memwrite_d = 1'b0;
        end else if (!stall) begin
            if (exc_cond) begin
                valid_d    = 1'b0;
                regwrite_d = 1'b0;
                memread_d  = 1'b0;
                memwrite_d = 1'b0;
                exc_req_d  = 1'b1;
                exc_code_d = rsvd ? 2'b01 : 2'b10;
                epc_d      = ex_pc;
                state_d    = S_EXC;
            end else begin
                valid_d    = ex_valid;
                result_d   = result;
                zero_d     = result == '0;
                wdata_d    = ex_wdata;
                rd_d       = ex_rd;
                regwrite_d = ex_valid & ex_regwrite;
                memread_d  = ex_valid & ex_memread;
                memwrite_d = ex_valid & ex_memwrite;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            valid_q    <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            wdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            exc_req_q  <= 1'b0;
            exc_code_q <= 2'b00;
            epc_q      <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            exc_req_q  <= exc_req_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end
    assign mem_valid      = valid_q;
    assign mem_alu_result = result_q;
    assign mem_zero       = zero_q;
    assign mem_wdata      = wdata_q;
    assign mem_rd         = rd_q;
    assign mem_regwrite   = regwrite_q;
    assign mem_memread    = memread_q;
    assign mem_memwrite   = memwrite_q;
    assign exc_req        = exc_req_q;
    assign exc_code       = exc_code_q;
    assign exc_epc        = epc_q;
endmodule

// File: tb/tb_ex_alu_stage.sv
// tb_ex_alu_stage: directed checks of ex_alu_stage, trapping and non-trapping overflow
module tb_ex_alu_stage;
    logic clk = 0, rst_n = 0;
    logic ex_valid, undefine, ex_regwrite, ex_memread, ex_memwrite, stall, flush, exc_ack;
    logic [2:0] op;
    logic [31:0] ex_a, ex_b, ex_wdata, ex_pc;
    logic [4:0] ex_rd;
    logic mem_valid, mem_zero, mem_regwrite, mem_memread, mem_memwrite, exc_req;
    logic [31:0] mem_alu_result, mem_wdata, exc_epc;
    logic [4:0] mem_rd;
    logic [1:0] exc_code;
    logic n_valid, n_zero, n_regwrite, n_memread, n_memwrite, n_exc_req;
    logic [31:0] n_result, n_wdata, n_epc;
    logic [4:0] n_rd;
    logic [1:0] n_code;
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    ex_alu_stage #(.WIDTH(32), .OVF_TRAP(1)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .AluCtrlOut(op), .undefine(undefine),
        .ex_a(ex_a), .ex_b(ex_b), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_pc(ex_pc), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_zero(mem_zero),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc)
    );
    ex_alu_stage #(.WIDTH(32), .OVF_TRAP(0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .AluCtrlOut(op), .undefine(undefine),
        .ex_a(ex_a), .ex_b(ex_b), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_pc(ex_pc), .stall(stall), .flush(flush), .exc_ack(exc_ack),
        .mem_valid(n_valid), .mem_alu_result(n_result), .mem_zero(n_zero),
        .mem_wdata(n_wdata), .mem_rd(n_rd), .mem_regwrite(n_regwrite),
        .mem_memread(n_memread), .mem_memwrite(n_memwrite),
        .exc_req(n_exc_req), .exc_code(n_code), .exc_epc(n_epc)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        ex_valid = 0; undefine = 0; op = 3'b000;
        ex_a = 0; ex_b = 0; ex_wdata = 0; ex_rd = 0; ex_pc = 0;
        ex_regwrite = 0; ex_memread = 0; ex_memwrite = 0;
        stall = 0; flush = 0; exc_ack = 0;
    endtask
    task automatic instr(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] pc);
        idle();
        ex_valid = 1; op = o; ex_a = a; ex_b = b; ex_rd = rd; ex_pc = pc; ex_regwrite = 1;
    endtask
    initial begin
        idle();
        #3;
        check("reset_valid", 32'(mem_valid), 32'd0);
        check("reset_result", mem_alu_result, 32'd0);
        check("reset_exc_req", 32'(exc_req), 32'd0);
        check("reset_epc", exc_epc, 32'd0);
        step();
        step();
        rst_n = 1;
        instr(3'b010, 32'd5, 32'd3, 5'd8, 32'h0040_0000);
        ex_wdata = 32'h0000_00AA;
        step();
        check("add_result", mem_alu_result, 32'd8);
        check("add_zero", 32'(mem_zero), 32'd0);
        check("add_rd", 32'(mem_rd), 32'd8);
        check("add_regwrite", 32'(mem_regwrite), 32'd1);
        check("add_valid", 32'(mem_valid), 32'd1);
        check("add_wdata", mem_wdata, 32'h0000_00AA);
        instr(3'b110, 32'd7, 32'd7, 5'd9, 32'h0);
        step();
        check("sub_result", mem_alu_result, 32'd0);
        check("sub_zero", 32'(mem_zero), 32'd1);
        instr(3'b111, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'h0);
        step();
        check("slt_result", mem_alu_result, 32'd1);
        instr(3'b111, 32'd1, 32'hFFFF_FFFF, 5'd9, 32'h0);
        step();
        check("slt_false", mem_alu_result, 32'd0);
        instr(3'b101, 32'hDEAD_BEEF, 32'hFFFF_1234, 5'd9, 32'h0);
        step();
        check("lui_result", mem_alu_result, 32'h1234_0000);
        instr(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9, 32'h0);
        step();
        check("and_result", mem_alu_result, 32'hF000_F000);
        instr(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9, 32'h0);
        step();
        check("or_result", mem_alu_result, 32'hFFF0_FFF0);
        instr(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9, 32'h0);
        step();
        check("xor_result", mem_alu_result, 32'h0FF0_0FF0);
        instr(3'b010, 32'd1, 32'd1, 5'd9, 32'h0);
        ex_valid = 0; ex_memwrite = 1;
        step();
        check("bubble_valid", 32'(mem_valid), 32'd0);
        check("bubble_regwrite", 32'(mem_regwrite), 32'd0);
        check("bubble_memwrite", 32'(mem_memwrite), 32'd0);
        instr(3'b010, 32'd1, 32'd2, 5'd5, 32'h0);
        exc_ack = 1;
        step();
        check("ack_in_run_result", mem_alu_result, 32'd3);
        check("ack_in_run_exc", 32'(exc_req), 32'd0);
        instr(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd10, 32'h0040_0010);
        step();
        check("ovf_valid", 32'(mem_valid), 32'd0);
        check("ovf_regwrite", 32'(mem_regwrite), 32'd0);
        check("ovf_exc_req", 32'(exc_req), 32'd1);
        check("ovf_code", 32'(exc_code), 32'd2);
        check("ovf_epc", exc_epc, 32'h0040_0010);
        check("nt_result", n_result, 32'h8000_0000);
        check("nt_valid", 32'(n_valid), 32'd1);
        check("nt_exc_req", 32'(n_exc_req), 32'd0);
        instr(3'b010, 32'd4, 32'd4, 5'd11, 32'h0040_0014);
        for (int i = 0; i < 3; i++) begin
            stall = (i == 1);
            flush = (i == 2);
            step();
            check("exc_hold_req", 32'(exc_req), 32'd1);
            check("exc_hold_code", 32'(exc_code), 32'd2);
            check("exc_hold_epc", exc_epc, 32'h0040_0010);
            check("exc_hold_valid", 32'(mem_valid), 32'd0);
        end
        flush = 0;
        exc_ack = 1;
        step();
        check("ack_req", 32'(exc_req), 32'd0);
        check("ack_code", 32'(exc_code), 32'd0);
        check("ack_epc", exc_epc, 32'h0040_0010);
        check("ack_valid", 32'(mem_valid), 32'd0);
        exc_ack = 0;
        step();
        check("resume_result", mem_alu_result, 32'd8);
        check("resume_valid", 32'(mem_valid), 32'd1);
        instr(3'b110, 32'h8000_0000, 32'd1, 5'd12, 32'h0040_0020);
        step();
        check("subovf_code", 32'(exc_code), 32'd2);
        check("subovf_epc", exc_epc, 32'h0040_0020);
        exc_ack = 1;
        step();
        instr(3'b100, 32'd1, 32'd1, 5'd13, 32'h0040_0030);
        undefine = 1;
        flush = 1;
        step();
        check("flush_exc_req", 32'(exc_req), 32'd0);
        check("flush_valid", 32'(mem_valid), 32'd0);
        flush = 0;
        step();
        check("rsvd_req", 32'(exc_req), 32'd1);
        check("rsvd_code", 32'(exc_code), 32'd1);
        check("rsvd_epc", exc_epc, 32'h0040_0030);
        exc_ack = 1;
        step();
        instr(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd13, 32'h0040_0034);
        undefine = 1;
        step();
        check("prio_code", 32'(exc_code), 32'd1);
        exc_ack = 1;
        step();
        instr(3'b010, 32'd10, 32'd20, 5'd3, 32'h0);
        step();
        check("pre_stall_result", mem_alu_result, 32'd30);
        instr(3'b010, 32'd100, 32'd200, 5'd4, 32'h0);
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_result", mem_alu_result, 32'd30);
            check("stall_rd", 32'(mem_rd), 32'd3);
            check("stall_valid", 32'(mem_valid), 32'd1);
        end
        stall = 0;
        step();
        check("unstall_result", mem_alu_result, 32'd300);
        check("unstall_rd", 32'(mem_rd), 32'd4);
        instr(3'b000, 32'd0, 32'd0, 5'd6, 32'h0040_0040);
        undefine = 1;
        stall = 1;
        step();
        check("stall_no_exc", 32'(exc_req), 32'd0);
        stall = 0;
        step();
        check("stall_reeval_exc", 32'(exc_req), 32'd1);
        check("stall_reeval_epc", exc_epc, 32'h0040_0040);
        #2;
        rst_n = 0;
        #1;
        check("rst_exc_req", 32'(exc_req), 32'd0);
        check("rst_code", 32'(exc_code), 32'd0);
        check("rst_epc", exc_epc, 32'd0);
        check("rst_valid", 32'(mem_valid), 32'd0);
        check("rst_result", mem_alu_result, 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        step();
        rst_n = 1;
        instr(3'b010, 32'd40, 32'd2, 5'd7, 32'h0);
        step();
        check("post_rst_result", mem_alu_result, 32'd42);
        check("post_rst_valid", 32'(mem_valid), 32'd1);
        check("post_rst_exc", 32'(exc_req), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
